// File: rtl/cordic_vector_iter_if.sv
// Handshake bundle for cordic_vector_iter: I/Q sample in, magnitude/phase out.
// The design sits on the slave side, while the upstream/downstream user drives the master side.
interface cordic_vector_iter_if #(
  parameter int XY_WIDTH = 16,
  parameter int Z_WIDTH  = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [XY_WIDTH-1:0] xin;
  logic signed [XY_WIDTH-1:0] yin;
  logic                       out_valid;
  logic                       out_ready;
  logic        [XY_WIDTH+1:0] mag_out;
  logic        [Z_WIDTH-1:0]  phase_out;

  modport master (
    output in_valid, xin, yin, out_ready,
    input  in_ready, out_valid, mag_out, phase_out
  );

  modport slave (
    input  in_valid, xin, yin, out_ready,
    output in_ready, out_valid, mag_out, phase_out
  );
endinterface

// File: rtl/cordic_vector_iter.sv
// cordic_vector_iter: iterative vectoring-mode CORDIC (I/Q -> magnitude, phase).
// One micro-rotation per clock and one conversion in flight at a time.
// Optional feature macro CORDIC_GAIN_COMP_EN: when defined, a one-cycle SCALE state
// multiplies x by ~1/K so that mag_out approximates the true magnitude.
// Z_WIDTH is limited to 31 because the arctangent table holds 32 fractional bits.
module cordic_vector_iter #(
  parameter int XY_WIDTH = 16,
  parameter int Z_WIDTH  = 16,
  parameter int STAGES   = 14
) (
  input logic            clock,
  input logic            reset_n,
  cordic_vector_iter_if.slave bus
);

  localparam int W     = XY_WIDTH + 3;
  localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CNT_W-1:0]   LAST        = CNT_W'(STAGES - 1);
  localparam logic [Z_WIDTH-1:0] QUARTER     = {2'b01, {(Z_WIDTH-2){1'b0}}};
  localparam logic [Z_WIDTH-1:0] NEG_QUARTER = {2'b11, {(Z_WIDTH-2){1'b0}}};

  typedef enum logic [2:0] {IDLE, PRE, ITER, SCALE, DONE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]  x_q, y_q;
  logic [Z_WIDTH-1:0]   z_q;
  logic [CNT_W-1:0]     iter_cnt;
  logic                 zero_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [XY_WIDTH+1:0]  mag_q;
  logic [Z_WIDTH-1:0]   phase_q;

  logic signed [W-1:0]  x_fold, y_fold;
  logic [Z_WIDTH-1:0]   z_fold;
  logic signed [W-1:0]  x_iter, y_iter;
  logic [Z_WIDTH-1:0]   z_iter;
  logic [Z_WIDTH-1:0]   atan_i;

  logic capture, do_fold, do_iter, load_out, in_ready_d;
`ifdef CORDIC_GAIN_COMP_EN
  logic                 do_scale;
  logic signed [W-1:0]  x_scaled;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mag_out   = mag_q;
  assign bus.phase_out = phase_q;

  // atan(2^-i) as a fraction of the full circle with 32 fractional bits, rounded to Z_WIDTH.
  function automatic logic [Z_WIDTH-1:0] atan_rom(input int idx);
    logic [31:0] frac;
    case (idx)
      0:  frac = 32'h20000000;
      1:  frac = 32'h12E4051E;
      2:  frac = 32'h09FB385B;
      3:  frac = 32'h051111D4;
      4:  frac = 32'h028B0D43;
      5:  frac = 32'h0145D7E1;
      6:  frac = 32'h00A2F61E;
      7:  frac = 32'h00517C55;
      8:  frac = 32'h0028BE53;
      9:  frac = 32'h00145F2F;
      10: frac = 32'h000A2F98;
      11: frac = 32'h000517CC;
      12: frac = 32'h00028BE6;
      13: frac = 32'h000145F3;
      14: frac = 32'h0000A2FA;
      15: frac = 32'h0000517D;
      16: frac = 32'h000028BE;
      17: frac = 32'h0000145F;
      18: frac = 32'h00000A30;
      19: frac = 32'h00000518;
      20: frac = 32'h0000028C;
      21: frac = 32'h00000146;
      22: frac = 32'h000000A3;
      23: frac = 32'h00000051;
      24: frac = 32'h00000029;
      25: frac = 32'h00000014;
      26: frac = 32'h0000000A;
      27: frac = 32'h00000005;
      28: frac = 32'h00000003;
      29: frac = 32'h00000001;
      30: frac = 32'h00000001;
      default: frac = 32'h00000000;
    endcase
    return Z_WIDTH'((frac >> (32 - Z_WIDTH)) + 32'(frac[31 - Z_WIDTH]));
  endfunction

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, fold, iterate, optional scale, hold result until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) state_d = PRE;
      PRE:  state_d = ITER;
      ITER: if (iter_cnt == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
        state_d = SCALE;
`else
        state_d = DONE;
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      SCALE: state_d = DONE;
`endif
      DONE: if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes; in_ready is registered from the next state so it drops on accept.
  always_comb begin
    capture    = (state_q == IDLE) && bus.in_valid && in_ready_q;
    do_fold    = (state_q == PRE);
    do_iter    = (state_q == ITER);
    load_out   = (state_q == DONE) && !out_valid_q;
    in_ready_d = (state_d == IDLE);
`ifdef CORDIC_GAIN_COMP_EN
    do_scale   = (state_q == SCALE);
`endif
  end

  // Quadrant fold into the right half-plane so the iterations only need +/-90 deg of range.
  always_comb begin
    x_fold = x_q;
    y_fold = y_q;
    z_fold = '0;
    if (x_q[W-1]) begin
      if (!y_q[W-1]) begin
        x_fold = y_q;
        y_fold = -x_q;
        z_fold = QUARTER;
      end else begin
        x_fold = -y_q;
        y_fold = x_q;
        z_fold = NEG_QUARTER;
      end
    end
  end

  // One micro-rotation steering y toward zero; shifts use the pre-update x and y.
  always_comb begin
    atan_i = atan_rom(int'(iter_cnt));
    if (!y_q[W-1]) begin
      x_iter = x_q + (y_q >>> iter_cnt);
      y_iter = y_q - (x_q >>> iter_cnt);
      z_iter = z_q + atan_i;
    end else begin
      x_iter = x_q - (y_q >>> iter_cnt);
      y_iter = y_q + (x_q >>> iter_cnt);
      z_iter = z_q - atan_i;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  // Shift-add approximation of 1/K (~0.6074) to undo the CORDIC gain.
  always_comb begin
    x_scaled = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
  end
`endif

  // Datapath, iteration counter and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      iter_cnt    <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      phase_q     <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      if (capture) begin
        x_q <= {{3{bus.xin[XY_WIDTH-1]}}, bus.xin};
        y_q <= {{3{bus.yin[XY_WIDTH-1]}}, bus.yin};
      end
      if (do_fold) begin
        x_q      <= x_fold;
        y_q      <= y_fold;
        z_q      <= z_fold;
        zero_q   <= (x_q == '0) && (y_q == '0);
        iter_cnt <= '0;
      end
      if (do_iter) begin
        x_q      <= x_iter;
        y_q      <= y_iter;
        z_q      <= z_iter;
        iter_cnt <= (iter_cnt == LAST) ? '0 : iter_cnt + CNT_W'(1);
      end
`ifdef CORDIC_GAIN_COMP_EN
      if (do_scale) x_q <= x_scaled;
`endif
      if (load_out) begin
        out_valid_q <= 1'b1;
        mag_q       <= zero_q ? '0 : x_q[XY_WIDTH+1:0];
        phase_q     <= zero_q ? '0 : z_q;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Testbench for cordic_vector_iter: real-math reference model feeding a scoreboard,
// with a monitor that checks latency and results on every output handshake.
module tb_cordic_vector_iter;

  localparam int XY_WIDTH = 16;
  localparam int Z_WIDTH  = 16;
  localparam int STAGES   = 14;
  localparam longint FULL = 64'd1 << Z_WIDTH;
  localparam real    PI   = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam longint LAT     = STAGES + 3;
  localparam real    SCALE_F = 0.5 + 0.125 - 1.0/64.0 - 1.0/512.0;
  localparam longint M1_TOL  = 4;
`else
  localparam longint LAT     = STAGES + 2;
  localparam real    SCALE_F = 1.0;
  localparam longint M1_TOL  = 3;
`endif

  typedef struct {
    longint mag;
    longint phase;
    longint mag_tol;
    longint ph_tol;
    longint accept_edge;
  } exp_t;

  logic   clock;
  logic   reset_n;
  longint cycle_cnt = 0;
  int     n_checks  = 0;
  int     n_errors  = 0;
  bit     prev_valid = 1'b0;
  exp_t   sb[$];

  cordic_vector_iter_if #(.XY_WIDTH(XY_WIDTH), .Z_WIDTH(Z_WIDTH)) bus_if ();

  cordic_vector_iter #(.XY_WIDTH(XY_WIDTH), .Z_WIDTH(Z_WIDTH), .STAGES(STAGES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // Free-running clock and edge counter.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle_cnt++;

  // Compares with an optional tolerance; a nonzero modulus makes the difference circular.
  task automatic check_output(input string tag, input longint obs, input longint exp,
                              input longint tol, input longint modulus);
    longint diff;
    n_checks++;
    diff = obs - exp;
    if (modulus > 0) begin
      diff = diff % modulus;
      if (diff < 0) diff += modulus;
      if (diff >= modulus / 2) diff -= modulus;
    end
    if (diff > tol || diff < -tol) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // Reference: K * |v| (optionally scaled) and atan2 as a fraction of the full circle.
  function automatic exp_t model(input int x, input int y, input longint mtol, input longint ptol);
    exp_t e;
    real  k, p, m, a;
    longint ph;
    k = 1.0;
    p = 1.0;
    for (int i = 0; i < STAGES; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p * 0.25;
    end
    e.accept_edge = 0;
    if (x == 0 && y == 0) begin
      e.mag = 0; e.phase = 0; e.mag_tol = 0; e.ph_tol = 0;
    end else begin
      m  = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * k * SCALE_F;
      a  = $atan2(real'(y), real'(x)) / (2.0 * PI) * real'(FULL);
      ph = longint'(a);
      if (ph < 0) ph += FULL;
      e.mag     = longint'(m);
      e.phase   = ph % FULL;
      e.mag_tol = mtol;
      e.ph_tol  = ptol;
    end
    return e;
  endfunction

  // Presents one sample, holds it until accepted and records the expectation.
  task automatic apply_stimulus(input int x, input int y, input longint mtol, input longint ptol,
                                output longint accept_edge);
    exp_t e;
    bit   done;
    e = model(x, y, mtol, ptol);
    accept_edge = -1;
    @(posedge clock); #1;
    bus_if.xin      = XY_WIDTH'(x);
    bus_if.yin      = XY_WIDTH'(y);
    bus_if.in_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      if (bus_if.in_ready) begin
        e.accept_edge = cycle_cnt + 1;
        accept_edge   = e.accept_edge;
        sb.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) check_output("accept_timeout", 0, 1, 0, 0);
    @(posedge clock); #1;
    bus_if.in_valid = 1'b0;
  endtask

  // Waits, bounded, until every expected result has been delivered.
  task automatic wait_drain();
    for (int c = 0; c < 200 && sb.size() > 0; c++) @(posedge clock);
    #1;
    check_output("drain", sb.size(), 0, 0, 0);
  endtask

  // Output monitor: latency on the rising out_valid, values on each handshake.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus_if.out_valid && !prev_valid) begin
        if (sb.size() > 0) check_output("latency", cycle_cnt - sb[0].accept_edge, LAT, 0, 0);
        else               check_output("unexpected_out_valid", 1, 0, 0, 0);
      end
      if (bus_if.out_valid && bus_if.out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check_output("mag_out",   longint'(bus_if.mag_out),   e.mag,   e.mag_tol, 0);
        check_output("phase_out", longint'(bus_if.phase_out), e.phase, e.ph_tol,  FULL);
      end
      prev_valid = bus_if.out_valid;
    end
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    longint acc;
    exp_t   hold_e;
    bit     seen;
    int     rx, ry;

    reset_n          = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.xin       = '0;
    bus_if.yin       = '0;
    bus_if.out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check_output("rst_in_ready",  bus_if.in_ready,  0, 0, 0);
    check_output("rst_out_valid", bus_if.out_valid, 0, 0, 0);
    check_output("rst_mag",       bus_if.mag_out,   0, 0, 0);
    check_output("rst_phase",     bus_if.phase_out, 0, 0, 0);
    #19 reset_n = 1'b1;
    #1 check_output("in_ready_before_clock", bus_if.in_ready, 0, 0, 0);
    @(posedge clock); #1;
    check_output("in_ready_after_clock", bus_if.in_ready, 1, 0, 0);

    // Axis points, the most negative corner and the zero vector.
    $display("[TB] axis and corner vectors");
    apply_stimulus(10000, 0, M1_TOL, 2, acc);
    apply_stimulus(0, 10000, 4, 2, acc);
    apply_stimulus(-10000, 0, 4, 2, acc);
    apply_stimulus(-32768, -32768, 8, 2, acc);
    apply_stimulus(0, 0, 0, 0, acc);
    wait_drain();

    // Random vectors across all quadrants with magnitude well above the quantisation floor.
    $display("[TB] random vectors");
    for (int n = 0; n < 6; n++) begin
      rx = int'($urandom_range(8000, 30000));
      if ($urandom_range(0, 1) == 1) rx = -rx;
      ry = int'($urandom_range(0, 60000)) - 30000;
      if (n % 2 == 1) begin
        int t;
        t = rx; rx = ry; ry = t;
      end
      apply_stimulus(rx, ry, 10, 6, acc);
    end
    wait_drain();

    // Backpressure: result must hold, input must be refused, then IDLE after the handshake.
    $display("[TB] backpressure");
    @(posedge clock); #1;
    bus_if.out_ready = 1'b0;
    hold_e = model(12000, -5000, 8, 3);
    apply_stimulus(12000, -5000, 8, 3, acc);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clock);
      seen = bus_if.out_valid;
    end
    check_output("hold_out_valid_seen", seen, 1, 0, 0);
    @(posedge clock); #1;
    bus_if.xin      = XY_WIDTH'(-20000);
    bus_if.yin      = XY_WIDTH'(7);
    bus_if.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_output("hold_out_valid", bus_if.out_valid, 1, 0, 0);
      check_output("hold_in_ready",  bus_if.in_ready,  0, 0, 0);
      check_output("hold_mag",   longint'(bus_if.mag_out),   hold_e.mag,   hold_e.mag_tol, 0);
      check_output("hold_phase", longint'(bus_if.phase_out), hold_e.phase, hold_e.ph_tol,  FULL);
    end
    @(posedge clock); #1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clock); #1;
    check_output("release_in_ready",  bus_if.in_ready,  1, 0, 0);
    check_output("release_out_valid", bus_if.out_valid, 0, 0, 0);
    repeat (25) @(posedge clock);
    check_output("no_ghost_result", sb.size(), 0, 0, 0);

    // Reset pulse while iteration 7 is running: everything clears, no output appears.
    $display("[TB] reset during iteration");
    apply_stimulus(15000, 9000, 10, 6, acc);
    while (cycle_cnt < acc + 8) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_output("abort_out_valid", bus_if.out_valid, 0, 0, 0);
    check_output("abort_mag",       bus_if.mag_out,   0, 0, 0);
    check_output("abort_phase",     bus_if.phase_out, 0, 0, 0);
    check_output("abort_in_ready",  bus_if.in_ready,  0, 0, 0);
    sb.delete();
    @(negedge clock); #2;
    reset_n = 1'b1;
    #1 check_output("abort_in_ready_released", bus_if.in_ready, 0, 0, 0);
    apply_stimulus(0, 10000, 4, 2, acc);
    apply_stimulus(-7000, -20000, 10, 6, acc);
    wait_drain();
    repeat (20) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
